// File: rtl/grid_renderer.sv
// grid_renderer
// Double-buffered block-grid renderer on the pixel clock. Game logic writes
// cell codes into the back bank while the display reads the front bank; the
// banks swap only at the first blanking line, so a frame never tears.
//
// Ports
//   pixel_clk, reset_rtl_0     clock, synchronous active-low reset
//   drawX, drawY               current pixel coordinates
//   hsync, vsync, vde          raw sync / active-video inputs
//   wr_en, wr_x, wr_y, wr_data cell write into the back bank
//   swap_req                   request a bank swap at the next blanking start
//   wr_err                     pulse, one cycle after an out-of-range write
//   swap_pending               swap FSM state (high while PENDING)
//   swap_ack                   high during the cycle the swap takes effect
//   red, green, blue           4-bit colour, 2 cycles after the coordinates
//   hsync_o, vsync_o, vde_o    sync inputs delayed to line up with RGB
//
// Handshake: wr_en and swap_req are single-cycle strobes with no ready; the
// block accepts every strobe in the cycle it is high. A write is dropped (and
// flagged on wr_err) only when its coordinates fall outside the grid; a
// swap_req while a swap is already pending is absorbed by that swap.
module grid_renderer #(
  parameter int          GRID_W     = 10,
  parameter int          GRID_H     = 22,
  parameter int          CELL_PX    = 20,
  parameter int          ORIGIN_X   = 220,
  parameter int          ORIGIN_Y   = 20,
  parameter int          CELL_BITS  = 3,
  parameter logic [11:0] BG_COLOR   = 12'h222,
  parameter logic [11:0] LINE_COLOR = 12'h444,
  parameter int          V_ACTIVE   = 480
) (
  input  logic                        pixel_clk,
  input  logic                        reset_rtl_0,
  input  logic [9:0]                  drawX,
  input  logic [9:0]                  drawY,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        vde,
  input  logic                        wr_en,
  input  logic [$clog2(GRID_W)-1:0]   wr_x,
  input  logic [$clog2(GRID_H)-1:0]   wr_y,
  input  logic [CELL_BITS-1:0]        wr_data,
  input  logic                        swap_req,
  output logic                        wr_err,
  output logic                        swap_pending,
  output logic                        swap_ack,
  output logic [3:0]                  red,
  output logic [3:0]                  green,
  output logic [3:0]                  blue,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic                        vde_o
);

  localparam int AW = $clog2(GRID_W * GRID_H);
  localparam int CW = $clog2(GRID_W + 1);
  localparam int RW = $clog2(GRID_H + 1);
  localparam int SW = $clog2(CELL_PX);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t state_q, state_d;
  logic   front;
  logic   do_swap;
  logic   swap_point;

  // ---------------- swap control ----------------
  assign swap_point = (int'(drawY) == V_ACTIVE) && (drawX == 10'd0);

  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      IDLE:    if (swap_req) state_d = PENDING;
      PENDING: if (swap_point) begin
        do_swap = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_rtl_0) begin
      state_q <= IDLE;
      front   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_swap) front <= ~front;
    end
  end

  assign swap_pending = (state_q == PENDING);
  // Gated by reset so the output is 0 even before the first reset edge.
  assign swap_ack     = do_swap & reset_rtl_0;

  // ---------------- cell storage ----------------
  logic                 wr_ok;
  logic [AW-1:0]        wr_cell;
  logic [AW-1:0]        rd_cell;
  logic [CELL_BITS-1:0] rd_data;
  logic [CELL_BITS-1:0] mem [0:(2**(AW+1))-1];

  assign wr_ok   = wr_en && (int'(wr_x) < GRID_W) && (int'(wr_y) < GRID_H);
  assign wr_cell = AW'(int'(wr_y) * GRID_W + int'(wr_x));

  // Writes hit only ~front and reads only front, so no same-address hazard.
  // rd_data is not reset: stage 2 only uses it when the in-grid flag (which
  // is reset) is set.
  always_ff @(posedge pixel_clk) begin
    if (wr_ok) mem[{~front, wr_cell}] <= wr_data;
    rd_data <= mem[{front, rd_cell}];
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_rtl_0) wr_err <= 1'b0;
    else              wr_err <= wr_en && !wr_ok;
  end

  // ---------------- grid position counters ----------------
  // *_q hold the position of the previous pixel/line; *_c is the position of
  // the pixel currently on drawX/drawY, so stage 1 can issue the read now.
  logic [CW-1:0] col_q, col_c;
  logic [RW-1:0] row_q, row_c;
  logic [SW-1:0] sub_x_q, sub_x_c, sub_y_q, sub_y_c;

  always_comb begin
    col_c   = col_q;
    sub_x_c = sub_x_q + 1'b1;
    if (int'(drawX) == ORIGIN_X) begin
      col_c   = '0;
      sub_x_c = '0;
    end else if (int'(sub_x_q) == CELL_PX - 1) begin
      sub_x_c = '0;
      // Saturate past the right edge so the column never wraps back in.
      if (int'(col_q) != GRID_W) col_c = col_q + 1'b1;
    end
  end

  always_comb begin
    row_c   = row_q;
    sub_y_c = sub_y_q;
    if (drawX == 10'd0) begin
      if (int'(drawY) == ORIGIN_Y) begin
        row_c   = '0;
        sub_y_c = '0;
      end else if (int'(sub_y_q) == CELL_PX - 1) begin
        sub_y_c = '0;
        if (int'(row_q) != GRID_H) row_c = row_q + 1'b1;
      end else begin
        sub_y_c = sub_y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_rtl_0) begin
      col_q   <= '0;
      row_q   <= '0;
      sub_x_q <= '0;
      sub_y_q <= '0;
    end else begin
      col_q   <= col_c;
      row_q   <= row_c;
      sub_x_q <= sub_x_c;
      sub_y_q <= sub_y_c;
    end
  end

  assign rd_cell = AW'(int'(row_c) * GRID_W + int'(col_c));

  // ---------------- pixel pipeline ----------------
  logic in_grid_c, line_c;
  logic s1_in_grid, s1_line, s1_vde, s1_hs, s1_vs;
  logic [11:0] rgb_q, pix_c;

  assign in_grid_c = (int'(drawX) >= ORIGIN_X) && (int'(col_c) < GRID_W) &&
                     (int'(drawY) >= ORIGIN_Y) && (int'(row_c) < GRID_H);
  assign line_c    = (sub_x_c == '0) || (sub_y_c == '0);

  function automatic logic [11:0] palette(input logic [CELL_BITS-1:0] code);
    case (int'(code))
      0:       palette = 12'h000;
      1:       palette = 12'h0FF;
      2:       palette = 12'hFF0;
      3:       palette = 12'h80F;
      4:       palette = 12'h0F0;
      5:       palette = 12'hF00;
      6:       palette = 12'h00F;
      7:       palette = 12'hF80;
      default: palette = 12'hFFF;
    endcase
  endfunction

  always_comb begin
    pix_c = 12'h000;
    if (s1_vde) begin
      if (!s1_in_grid)  pix_c = BG_COLOR;
      else if (s1_line) pix_c = LINE_COLOR;
      else              pix_c = palette(rd_data);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_rtl_0) begin
      s1_in_grid <= 1'b0;
      s1_line    <= 1'b0;
      s1_vde     <= 1'b0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      rgb_q      <= 12'h000;
      hsync_o    <= 1'b0;
      vsync_o    <= 1'b0;
      vde_o      <= 1'b0;
    end else begin
      s1_in_grid <= in_grid_c;
      s1_line    <= line_c;
      s1_vde     <= vde;
      s1_hs      <= hsync;
      s1_vs      <= vsync;
      rgb_q      <= pix_c;
      hsync_o    <= s1_hs;
      vsync_o    <= s1_vs;
      vde_o      <= s1_vde;
    end
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_grid_renderer.sv
// Testbench for grid_renderer. Uses a shrunken raster (44x74 total, 38x72
// active) and 3-pixel cells so many frames fit in a short run. The reference
// model is a pair of cell arrays plus a front-bank bit; expected pixels are
// computed from coordinates with division/modulo.
module tb_grid_renderer;

  localparam int GW    = 10;
  localparam int GH    = 22;
  localparam int CP    = 3;
  localparam int OX    = 6;
  localparam int OY    = 4;
  localparam int VA    = 72;
  localparam int H_ACT = 38;
  localparam int H_TOT = 44;
  localparam int V_TOT = 74;
  localparam int FRAME = H_TOT * V_TOT;

  logic       pixel_clk;
  logic       reset_rtl_0;
  logic [9:0] drawX, drawY;
  logic       hsync, vsync, vde;
  logic       wr_en;
  logic [3:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_data;
  logic       swap_req;
  logic       wr_err, swap_pending, swap_ack;
  logic [3:0] red, green, blue;
  logic       hsync_o, vsync_o, vde_o;

  grid_renderer #(
    .GRID_W(GW), .GRID_H(GH), .CELL_PX(CP), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .CELL_BITS(3), .BG_COLOR(12'h222), .LINE_COLOR(12'h444), .V_ACTIVE(VA)
  ) dut (
    .pixel_clk(pixel_clk), .reset_rtl_0(reset_rtl_0),
    .drawX(drawX), .drawY(drawY), .hsync(hsync), .vsync(vsync), .vde(vde),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .swap_req(swap_req), .wr_err(wr_err), .swap_pending(swap_pending),
    .swap_ack(swap_ack), .red(red), .green(green), .blue(blue),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .vde_o(vde_o)
  );

  // ---------------- clock ----------------
  initial pixel_clk = 1'b0;
  always #20 pixel_clk = ~pixel_clk;

  // ---------------- model state ----------------
  int       hx, vy;
  int       n_tests, n_fail;
  logic [2:0] model_mem [0:1][0:GH-1][0:GW-1];
  bit       model_front;

  function automatic logic [11:0] pal(input logic [2:0] c);
    logic [11:0] t [0:7];
    t = '{12'h000, 12'h0FF, 12'hFF0, 12'h80F, 12'h0F0, 12'hF00, 12'h00F, 12'hF80};
    return t[c];
  endfunction

  function automatic logic [11:0] exp_rgb(input int x, input int y);
    int gx, gy;
    gx = x - OX;
    gy = y - OY;
    if (!(x < H_ACT && y < VA)) return 12'h000;
    if (gx < 0 || gy < 0 || gx / CP >= GW || gy / CP >= GH) return 12'h222;
    if (gx % CP == 0 || gy % CP == 0) return 12'h444;
    return pal(model_mem[model_front ? 1 : 0][gy / CP][gx / CP]);
  endfunction

  function automatic logic s_hs(input int x); return !(x >= 39 && x < 42); endfunction
  function automatic logic s_vs(input int y); return !(y == 73); endfunction
  function automatic logic s_vde(input int x, input int y); return (x < H_ACT) && (y < VA); endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    drawX = 10'(hx);
    drawY = 10'(vy);
    hsync = s_hs(hx);
    vsync = s_vs(vy);
    vde   = s_vde(hx, vy);
  endtask

  // One pixel: advance raster at the falling edge, outputs settle by #1.
  task automatic step();
    @(negedge pixel_clk);
    hx++;
    if (hx == H_TOT) begin
      hx = 0;
      vy++;
      if (vy == V_TOT) vy = 0;
    end
    drive();
    #1;
  endtask

  task automatic run_to(input int x, input int y);
    for (int i = 0; i <= FRAME && !(hx == x && vy == y); i++) step();
  endtask

  task automatic write_cell(input int x, input int y, input int d);
    wr_en   = 1'b1;
    wr_x    = 4'(x);
    wr_y    = 5'(y);
    wr_data = 3'(d);
    if (x < GW && y < GH) model_mem[model_front ? 0 : 1][y][x] = 3'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic wait_swap(output bit found);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (swap_ack === 1'b1) begin
        found = 1'b1;
        model_front = ~model_front;
      end
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_pixels(input int nf);
    logic [14:0] exp_q[$];
    int          xy_q[$];
    logic [14:0] e;
    int          xy, bad;
    bad = 0;
    run_to(0, 0);
    for (int i = 0; i < nf * FRAME; i++) begin
      step();
      exp_q.push_back({s_vde(hx, vy), s_hs(hx), s_vs(vy), exp_rgb(hx, vy)});
      xy_q.push_back(vy * 1000 + hx);
      if (exp_q.size() > 2) begin
        e  = exp_q.pop_front();
        xy = xy_q.pop_front();
        n_tests++;
        if ({vde_o, hsync_o, vsync_o, red, green, blue} !== e) begin
          n_fail++;
          if (bad < 10)
            $display("FAIL pixel x=%0d y=%0d got %h expected %h", xy % 1000, xy / 1000,
                     {vde_o, hsync_o, vsync_o, red, green, blue}, e);
          bad++;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [2:0] sq[$];
    logic [2:0] e;
    run_to(20, 30);
    reset_rtl_0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if ({red, green, blue, hsync_o, vsync_o, vde_o, wr_err, swap_ack, swap_pending} !== 0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got %h expected 0", i,
                 {red, green, blue, hsync_o, vsync_o, vde_o, wr_err, swap_ack, swap_pending});
      end
    end
    reset_rtl_0 = 1'b1;
    model_front = 1'b0;
    sq.push_back(3'b000);
    sq.push_back({s_vde(hx, vy), s_hs(hx), s_vs(vy)});
    for (int i = 0; i < 60; i++) begin
      step();
      e = sq.pop_front();
      sq.push_back({s_vde(hx, vy), s_hs(hx), s_vs(vy)});
      n_tests++;
      if ({vde_o, hsync_o, vsync_o} !== e) begin
        n_fail++;
        $display("FAIL reset_sync cycle %0d got %b expected %b", i, {vde_o, hsync_o, vsync_o}, e);
      end
      if (i == 0 || e[2] == 1'b0) begin
        n_tests++;
        if ({red, green, blue} !== 12'h000) begin
          n_fail++;
          $display("FAIL reset_rgb_zero cycle %0d got %h expected 000", i, {red, green, blue});
        end
      end
    end
  endtask

  task automatic test_write_swap();
    int bad;
    run_to(0, 0);
    write_cell(3, 5, 2);
    run_to(0, 50);
    pulse_swap();
    n_tests++;
    if (swap_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL ws_pending_set got %b expected 1", swap_pending);
    end
    bad = 0;
    for (int i = 0; i <= FRAME && !(hx == 0 && vy == VA); i++) begin
      if (swap_pending !== 1'b1 || swap_ack !== 1'b0) bad++;
      step();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ws_pending_hold bad_cycles=%0d expected 0", bad);
    end
    n_tests++;
    if (swap_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL ws_ack_at_swap got %b expected 1", swap_ack);
    end
    model_front = ~model_front;
    step();
    n_tests++;
    if ({swap_pending, swap_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL ws_after_swap got %b expected 00", {swap_pending, swap_ack});
    end
    run_to(OX + 3 * CP + 1, OY + 5 * CP + 1);
    step();
    step();
    n_tests++;
    if ({red, green, blue} !== 12'hFF0) begin
      n_fail++;
      $display("FAIL ws_pixel got %h expected FF0", {red, green, blue});
    end
  endtask

  task automatic test_write_no_swap();
    logic [11:0] old_v;
    old_v = pal(model_mem[model_front ? 1 : 0][0][0]);
    write_cell(0, 0, 5);
    for (int f = 0; f < 2; f++) begin
      run_to(OX + 1, OY + 1);
      step();
      step();
      n_tests++;
      if ({red, green, blue} !== old_v) begin
        n_fail++;
        $display("FAIL noswap_pixel frame %0d got %h expected %h", f, {red, green, blue}, old_v);
      end
    end
  endtask

  task automatic test_oob();
    int xs[3] = '{10, 4, 3};
    int ys[3] = '{3, 22, 3};
    for (int k = 0; k < 3; k++) begin
      write_cell(xs[k], ys[k], 7);
      n_tests++;
      if (wr_err !== (k < 2)) begin
        n_fail++;
        $display("FAIL oob_err_pulse k=%0d got %b expected %b", k, wr_err, k < 2);
      end
      step();
      n_tests++;
      if (wr_err !== 1'b0) begin
        n_fail++;
        $display("FAIL oob_err_clear k=%0d got %b expected 0", k, wr_err);
      end
    end
  endtask

  task automatic test_regions();
    int          px[4] = '{OX - 1, 38, OX + CP, 40};
    int          py[4] = '{OY + 1, OY + 1, OY + CP + 1, 10};
    logic [14:0] ex[4] = '{{3'b111, 12'h222}, {3'b011, 12'h000},
                           {3'b111, 12'h444}, {3'b001, 12'h000}};
    run_to(0, 0);
    for (int k = 0; k < 4; k++) begin
      run_to(px[k], py[k]);
      step();
      step();
      n_tests++;
      if ({vde_o, hsync_o, vsync_o, red, green, blue} !== ex[k]) begin
        n_fail++;
        $display("FAIL region k=%0d got %h expected %h", k,
                 {vde_o, hsync_o, vsync_o, red, green, blue}, ex[k]);
      end
    end
  endtask

  task automatic test_swap_collision();
    int acks;
    bit seen, found;
    run_to(0, 10);
    pulse_swap();
    run_to(0, 40);
    pulse_swap();
    acks = 0;
    for (int i = 0; i <= FRAME && !(hx == 0 && vy == VA); i++) begin
      if (swap_ack === 1'b1) acks++;
      step();
    end
    seen = (swap_ack === 1'b1);
    if (seen) acks++;
    write_cell(2, 2, 7);   // lands in the swap cycle
    if (seen) model_front = ~model_front;
    run_to(OX + 2 * CP + 1, OY + 2 * CP + 1);
    step();
    step();
    n_tests++;
    if ({red, green, blue} !== 12'hF80) begin
      n_fail++;
      $display("FAIL coll_swap_cycle_write got %h expected F80", {red, green, blue});
    end
    for (int i = 0; i <= FRAME && !(hx == 0 && vy == VA); i++) begin
      if (swap_ack === 1'b1) acks++;
      step();
    end
    if (swap_ack === 1'b1) acks++;
    n_tests++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL coll_one_toggle acks=%0d expected 1", acks);
    end
    // Request in the swap cycle while IDLE: swaps one frame later.
    swap_req = 1'b1;
    n_tests++;
    if (swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_idle_req_ack got %b expected 0", swap_ack);
    end
    step();
    swap_req = 1'b0;
    n_tests++;
    if (swap_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_idle_req_pending got %b expected 1", swap_pending);
    end
    wait_swap(found);
    n_tests++;
    if (!found || swap_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_late_swap found=%0d pending=%b expected 1/0", found, swap_pending);
    end
  endtask

  task automatic test_random(input int rounds);
    int x, y;
    bit found;
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < 24; k++) begin
        x = $urandom_range(0, GW);
        y = $urandom_range(0, GH - 1);
        write_cell(x, y, $urandom_range(0, 7));
        n_tests++;
        if (wr_err !== (x >= GW)) begin
          n_fail++;
          $display("FAIL rand_wr_err x=%0d got %b expected %b", x, wr_err, x >= GW);
        end
      end
      pulse_swap();
      wait_swap(found);
      n_tests++;
      if (!found) begin
        n_fail++;
        $display("FAIL rand_swap_timeout round %0d got none expected swap", r);
      end
      test_pixels(1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    n_tests = 0;
    n_fail  = 0;
    hx = 0;
    vy = 0;
    model_front = 1'b0;
    reset_rtl_0 = 1'b0;
    wr_en = 1'b0;
    wr_x = '0;
    wr_y = '0;
    wr_data = '0;
    swap_req = 1'b0;
    drive();
    for (int i = 0; i < 5; i++) step();
    reset_rtl_0 = 1'b1;

    // RAM powers up undefined: fill both banks with random codes.
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) write_cell(x, y, $urandom_range(0, 7));
    pulse_swap();
    wait_swap(found);
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL init_swap got none expected swap");
    end
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) write_cell(x, y, $urandom_range(0, 7));

    test_pixels(1);
    test_reset();
    test_write_swap();
    test_write_no_swap();
    test_oob();
    test_regions();
    test_swap_collision();
    test_random(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
